// File: rtl/cfg_pkg.sv
// Shared definitions for the host-link configuration path: FSM states, frame
// constants and width helpers also used by the register decoders.
package cfg_pkg;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    DATA,
    CSUM,
    WRITE
  } cfg_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Bits needed to represent 0..max_val; never less than one bit.
  function automatic int width_of(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Whole bytes needed to carry a value of the given bit width.
  function automatic int num_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/cfg_timeout.sv
// Inter-byte watchdog: loadable down-counter that pulses expire when TIMEOUT
// cycles pass after a load with neither a new load nor a clear.
module cfg_timeout
  import cfg_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  localparam int CNT_W = width_of(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = CNT_W'(TIMEOUT);
    end else if (clear) begin
      count_next = '0;
    end else if (count_reg != '0) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A fresh load in the final cycle wins over expiry.
  assign expire = !load && !clear && (count_reg == CNT_W'(1));

endmodule

// File: rtl/cfg_writer.sv
// Host byte stream -> parameter-bus bridge: frames SYNC, ADDR, data bytes (MSB
// first) become a one-cycle en write. Define CFG_WRITER_CSUM_EN for an XOR checksum byte.
module cfg_writer
  import cfg_pkg::*;
#(
  parameter int         DATA_MAX  = 255,
  parameter int         ADDR_MAX  = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1000,
  localparam int        DATA_W    = width_of(DATA_MAX),
  localparam int        ADDR_W    = width_of(ADDR_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              err,
  output logic              busy
);

  localparam int               NB         = num_bytes(DATA_W);
  localparam int               SH_W       = NB * 8;
  localparam int               BCNT_W     = width_of(NB);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NB - 1);
  localparam logic [7:0]       ADDR_MAX_B = 8'(ADDR_MAX);

  cfg_state_e        state_reg, state_next;
  logic [7:0]        addr_byte_reg, addr_byte_next;
  logic [SH_W-1:0]   shift_reg, shift_next;
  logic [BCNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              en_reg, en_next;
  logic              err_reg, err_next;

  logic accept;
  logic addr_ok;
  logic expire;
  logic timer_clear;

`ifdef CFG_WRITER_CSUM_EN
  logic [7:0] csum_reg, csum_next;
  logic       csum_ok;
`endif

  assign rx_ready    = (state_reg != WRITE);
  assign accept      = rx_valid && rx_ready;
  assign addr_ok     = (addr_byte_reg <= ADDR_MAX_B);
  assign timer_clear = (state_reg == HUNT) || (state_reg == WRITE);

  cfg_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .clear (timer_clear),
    .expire(expire)
  );

  always_comb begin
    state_next     = state_reg;
    addr_byte_next = addr_byte_reg;
    shift_next     = shift_reg;
    byte_cnt_next  = byte_cnt_reg;
    data_next      = data_reg;
    addr_next      = addr_reg;
    en_next        = 1'b0;
    err_next       = 1'b0;
`ifdef CFG_WRITER_CSUM_EN
    csum_next      = csum_reg;
    csum_ok        = (rx_data == csum_reg);
`endif

    case (state_reg)
      HUNT: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_next = ADDR;
        end
      end

      ADDR: begin
        if (accept) begin
          addr_byte_next = rx_data;
          byte_cnt_next  = '0;
          shift_next     = '0;
          state_next     = DATA;
`ifdef CFG_WRITER_CSUM_EN
          csum_next      = rx_data;
`endif
        end else if (expire) begin
          err_next   = 1'b1;
          state_next = HUNT;
        end
      end

      DATA: begin
        if (accept) begin
          shift_next    = SH_W'({shift_reg, rx_data});
          byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
`ifdef CFG_WRITER_CSUM_EN
          csum_next     = csum_reg ^ rx_data;
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next = CSUM;
          end
`else
          // Outputs are loaded on the way into WRITE so they are valid with en.
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next = WRITE;
            if (addr_ok) begin
              en_next   = 1'b1;
              data_next = shift_next[DATA_W-1:0];
              addr_next = addr_byte_reg[ADDR_W-1:0];
            end else begin
              err_next = 1'b1;
            end
          end
`endif
        end else if (expire) begin
          err_next   = 1'b1;
          shift_next = '0;
          state_next = HUNT;
        end
      end

`ifdef CFG_WRITER_CSUM_EN
      CSUM: begin
        if (accept) begin
          if (!csum_ok) begin
            err_next   = 1'b1;
            state_next = HUNT;
          end else begin
            state_next = WRITE;
            if (addr_ok) begin
              en_next   = 1'b1;
              data_next = shift_reg[DATA_W-1:0];
              addr_next = addr_byte_reg[ADDR_W-1:0];
            end else begin
              err_next = 1'b1;
            end
          end
        end else if (expire) begin
          err_next   = 1'b1;
          shift_next = '0;
          state_next = HUNT;
        end
      end
`endif

      WRITE: begin
        state_next = HUNT;
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      addr_byte_reg <= '0;
      shift_reg     <= '0;
      byte_cnt_reg  <= '0;
      data_reg      <= '0;
      addr_reg      <= '0;
      en_reg        <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_byte_reg <= addr_byte_next;
      shift_reg     <= shift_next;
      byte_cnt_reg  <= byte_cnt_next;
      data_reg      <= data_next;
      addr_reg      <= addr_next;
      en_reg        <= en_next;
      err_reg       <= err_next;
    end
  end

`ifdef CFG_WRITER_CSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_reg <= '0;
    end else begin
      csum_reg <= csum_next;
    end
  end
`endif

  assign data = data_reg;
  assign addr = addr_reg;
  assign en   = en_reg;
  assign err  = err_reg;
  assign busy = (state_reg != HUNT);

endmodule
